// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the requester handshake, the FIFO write port and the status
//   signals of fifo_wr_arbiter.
//   slave  : arbiter side (drives req_ready, fifo_wr_en, fifo_din,
//            grant_valid, grant_id, err_overlen).
//   master : environment side (drives req_valid, req_last, req_data,
//            fifo_full, fifo_prog_full, err_clr).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_full;
  logic                          fifo_prog_full;
  logic                          grant_valid;
  logic [ID_W-1:0]               grant_id;
  logic                          err_overlen;
  logic                          err_clr;

  modport slave (
    input  req_valid, req_last, req_data, fifo_full, fifo_prog_full, err_clr,
    output req_ready, fifo_wr_en, fifo_din, grant_valid, grant_id, err_overlen
  );

  modport master (
    output req_valid, req_last, req_data, fifo_full, fifo_prog_full, err_clr,
    input  req_ready, fifo_wr_en, fifo_din, grant_valid, grant_id, err_overlen
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, packet-locked arbiter sharing one FIFO write port between
//   NUM_REQ requesters. A grant is held from first to last beat so packets
//   never interleave. New packets start only while fifo_prog_full is low.
//   A grant that reaches MAX_PKT_BEATS accepted beats without last is
//   released and flags err_overlen (sticky, cleared by err_clr).
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : fifo_wr_arbiter_if.slave
//           req_valid/req_last/req_data in, req_ready out (one-hot or zero)
//           fifo_wr_en/fifo_din out, fifo_full/fifo_prog_full in
//           grant_valid/grant_id/err_overlen out, err_clr in
module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_BEATS = 64
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic              valid_g;
  logic              last_g;
  logic [DATA_WIDTH-1:0] din_g;
  logic [NUM_REQ-1:0] ready;
  logic              wr_en;
  logic              set_err;

  // Round-robin pick: scan rr_last+1, rr_last+2, ... wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    cand       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx  = (32'(rr_last_q) + off) % NUM_REQ;
      cand = ID_W'(idx);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Granted requester's beat, selected combinationally from grant_id.
  always_comb begin
    din_g   = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) begin
        din_g   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        valid_g = bus.req_valid[i];
        last_g  = bus.req_last[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    ready      = '0;
    wr_en      = 1'b0;
    set_err    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found && !bus.fifo_prog_full) begin
          state_d    = LOCKED;
          grant_id_d = pick_id;
        end
      end
      LOCKED: begin
        ready[grant_id_q] = ~bus.fifo_full;
        wr_en             = valid_g & ~bus.fifo_full;
        if (wr_en) begin
          // Release when last arrives or when this beat is the MAX_PKT_BEATS-th;
          // last on the limit beat counts as a normal release.
          if (last_g || (beat_cnt_q == CNT_W'(MAX_PKT_BEATS - 1))) begin
            state_d    = IDLE;
            rr_last_d  = grant_id_q;
            beat_cnt_d = '0;
            set_err    = ~last_g;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over clear.
    if (set_err) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_last_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.fifo_wr_en  = wr_en;
  assign bus.fifo_din    = din_g;
  assign bus.grant_valid = (state_q == LOCKED);
  assign bus.grant_id    = grant_id_q;
  assign bus.err_overlen = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NR   = 4;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT_BEATS(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int wr_seen = 0;

  logic [DW:0]   src [NR][$];   // per-requester beats: {last, data}
  logic [DW-1:0] exp_q [$];     // scoreboard: expected FIFO write order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (src[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src[i].size() > 0) begin
        bus.req_valid[i]            = 1'b1;
        bus.req_last[i]             = src[i][0][DW];
        bus.req_data[i*DW +: DW]    = src[i][0][DW-1:0];
      end else begin
        bus.req_valid[i]            = 1'b0;
        bus.req_last[i]             = 1'b0;
        bus.req_data[i*DW +: DW]    = '0;
      end
    end
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  // Score the current cycle's write, retire accepted beats, then step one edge.
  task automatic adv();
    logic [DW-1:0] e;
    if (bus.fifo_wr_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) chk("sb_unexpected_write", bus.fifo_wr_en, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_din", bus.fifo_din, e);
      end
    end
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) void'(src[i].pop_front());
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic push_pkt(input int id, input int n, input logic [DW-1:0] base, input bit with_last);
    for (int k = 0; k < n; k++) begin
      src[id].push_back({(with_last && (k == n - 1)), base + DW'(k)});
      exp_q.push_back(base + DW'(k));
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) src[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(srcs_empty() && bus.grant_valid === 1'b0 && exp_q.size() == 0)) begin
      adv();
      n++;
    end
    chk(tag, (n < budget), 1);
  endtask

  initial begin
    int gq[$];
    int gap;
    bit prev_gv;
    bit first;
    int n;

    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_prog_full = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    apply();

    // Reset state
    chk("rst_grant_valid", bus.grant_valid, 0);
    chk("rst_grant_id",    bus.grant_id, 0);
    chk("rst_req_ready",   bus.req_ready, 0);
    chk("rst_wr_en",       bus.fifo_wr_en, 0);
    chk("rst_err",         bus.err_overlen, 0);

    // Single packet from requester 2
    wr_seen = 0;
    push_pkt(2, 3, 32'hA, 1'b1);
    apply();
    chk("t1_idle_gv", bus.grant_valid, 0);
    chk("t1_idle_wr", bus.fifo_wr_en, 0);
    adv();
    chk("t1_gid",   bus.grant_id, 2);
    chk("t1_gv",    bus.grant_valid, 1);
    chk("t1_ready", bus.req_ready, 4'b0100);
    chk("t1_wr0",   bus.fifo_wr_en, 1);
    adv();
    chk("t1_wr1",   bus.fifo_wr_en, 1);
    adv();
    chk("t1_wr2",   bus.fifo_wr_en, 1);
    adv();
    chk("t1_gv_drop", bus.grant_valid, 0);
    chk("t1_beats",   wr_seen, 3);

    // Round robin 0,1,3,0 with one idle cycle between packets
    do_reset();
    wr_seen = 0;
    push_pkt(0, 2, 32'h00, 1'b1);
    push_pkt(1, 2, 32'h10, 1'b1);
    push_pkt(3, 2, 32'h30, 1'b1);
    exp_q.delete();
    src[0].push_back({1'b0, 32'h02}); src[0].push_back({1'b1, 32'h03});
    exp_q.push_back(32'h00); exp_q.push_back(32'h01);
    exp_q.push_back(32'h10); exp_q.push_back(32'h11);
    exp_q.push_back(32'h30); exp_q.push_back(32'h31);
    exp_q.push_back(32'h02); exp_q.push_back(32'h03);
    apply();
    prev_gv = 1'b0; first = 1'b1; gap = 0; n = 0;
    while (n < 60 && !(srcs_empty() && bus.grant_valid === 1'b0)) begin
      if (bus.grant_valid && !prev_gv) begin
        gq.push_back(int'(bus.grant_id));
        if (!first) chk("t2_idle_gap", gap, 1);
        first = 1'b0;
        gap = 0;
      end else if (!bus.grant_valid) begin
        gap++;
      end
      prev_gv = bus.grant_valid;
      adv();
      n++;
    end
    chk("t2_budget", (n < 60), 1);
    chk("t2_ngrants", gq.size(), 4);
    chk("t2_g0", gq[0], 0);
    chk("t2_g1", gq[1], 1);
    chk("t2_g2", gq[2], 3);
    chk("t2_g3", gq[3], 0);
    chk("t2_beats", wr_seen, 8);

    // Backpressure: fifo_full for 4 cycles mid-packet
    wr_seen = 0;
    push_pkt(1, 6, 32'h40, 1'b1);
    apply();
    adv();
    chk("t3_gid", bus.grant_id, 1);
    adv();
    adv();
    bus.fifo_full = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_stall_ready", bus.req_ready, 0);
      chk("t3_stall_wr",    bus.fifo_wr_en, 0);
      chk("t3_stall_gv",    bus.grant_valid, 1);
      adv();
    end
    bus.fifo_full = 1'b0;
    #1;
    chk("t3_resume_wr", bus.fifo_wr_en, 1);
    drain("t3_drain", 20);
    chk("t3_beats", wr_seen, 6);

    // prog_full gating while idle; ignored while locked
    wr_seen = 0;
    bus.fifo_prog_full = 1'b1;
    push_pkt(1, 3, 32'h50, 1'b1);
    apply();
    for (int k = 0; k < 3; k++) begin
      chk("t4_blocked_gv", bus.grant_valid, 0);
      adv();
    end
    bus.fifo_prog_full = 1'b0;
    #1;
    adv();
    chk("t4_gv", bus.grant_valid, 1);
    chk("t4_gid", bus.grant_id, 1);
    bus.fifo_prog_full = 1'b1;
    #1;
    chk("t4_wr_under_pf", bus.fifo_wr_en, 1);
    drain("t4_drain", 20);
    bus.fifo_prog_full = 1'b0;
    chk("t4_beats", wr_seen, 3);

    // Overlength: 4 beats without last forces release
    wr_seen = 0;
    push_pkt(0, 4, 32'h60, 1'b0);
    apply();
    adv();
    for (int k = 0; k < 4; k++) begin
      chk("t5_wr", bus.fifo_wr_en, 1);
      adv();
    end
    chk("t5_released", bus.grant_valid, 0);
    chk("t5_err_set", bus.err_overlen, 1);
    bus.err_clr = 1'b1;
    adv();
    bus.err_clr = 1'b0;
    chk("t5_err_clr", bus.err_overlen, 0);
    push_pkt(0, 4, 32'h68, 1'b1);
    apply();
    drain("t5_drain_last", 20);
    chk("t5_last_on_limit_err", bus.err_overlen, 0);
    bus.err_clr = 1'b1;
    push_pkt(0, 4, 32'h6C, 1'b0);
    apply();
    drain("t5_drain_setwins", 20);
    chk("t5_set_wins", bus.err_overlen, 1);
    adv();
    bus.err_clr = 1'b0;
    chk("t5_err_clr2", bus.err_overlen, 0);

    // Async reset mid-packet, then 0 wins tie against 3
    clear_all();
    src[3].push_back({1'b0, 32'h70}); src[3].push_back({1'b0, 32'h71});
    src[3].push_back({1'b1, 32'h72});
    exp_q.push_back(32'h70);
    apply();
    adv();
    chk("t6_gid", bus.grant_id, 3);
    adv();
    chk("t6_wr_before", bus.fifo_wr_en, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_ready", bus.req_ready, 0);
    chk("t6_async_wr",    bus.fifo_wr_en, 0);
    chk("t6_async_gv",    bus.grant_valid, 0);
    chk("t6_sb_partial",  exp_q.size(), 0);
    clear_all();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_pkt(0, 1, 32'h80, 1'b1);
    push_pkt(3, 1, 32'h90, 1'b1);
    apply();
    chk("t6_idle_gv", bus.grant_valid, 0);
    adv();
    chk("t6_tie_gid", bus.grant_id, 0);
    chk("t6_tie_gv",  bus.grant_valid, 1);
    drain("t6_drain", 20);
    chk("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, packet-locked write arbiter that shares the single write port of a sync_fifo_asymm instance between NUM_REQ requesters. A grant is held from the first beat to the last beat of a packet, so packets never interleave in the FIFO. New packets start only when prog_full is low, which keeps headroom for the packet in flight. An overlength guard releases a requester that never sends last.

Parameters:
NUM_REQ, 4, number of write requesters (>=2)
DATA_WIDTH, 32, beat width; equals FIFO_DIN_WIDTH of the downstream FIFO
MAX_PKT_BEATS, 64, maximum accepted beats per grant before forced release (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last-beat marker, qualified by req_valid
req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot or zero; beat accepted when req_valid[i] & req_ready[i]
fifo_wr_en  out  1  to FIFO wr_en
fifo_din  out  DATA_WIDTH  to FIFO din
fifo_full  in  1  from FIFO full
fifo_prog_full  in  1  from FIFO prog_full
grant_valid  out  1  a requester is currently locked
grant_id  out  max(1,$clog2(NUM_REQ))  index of the locked requester; holds the last value when idle
err_overlen  out  1  sticky; set on a forced release
err_clr  in  1  synchronous clear of err_overlen

Behaviour:
- Reset (async assert, sync-safe deassert at clk edge) sets the following: state=IDLE, grant_valid=0, grant_id=0, req_ready=0, fifo_wr_en=0, err_overlen=0, beat_cnt=0, rr_last=NUM_REQ-1 (requester 0 has highest priority first). Reset mid-packet aborts the packet silently, and the partial packet stays in the FIFO.
- State IDLE: req_ready=0, fifo_wr_en=0. If any req_valid is set and fifo_prog_full=0, pick the first valid index scanning rr_last+1, rr_last+2, ... with wrap modulo NUM_REQ. On the next edge, register grant_id=that index and grant_valid=1, then go to LOCKED. Arbitration latency is 1 cycle, with no beat accepted in the IDLE cycle.
- State LOCKED (g=grant_id): req_ready[g]=~fifo_full and all other bits are 0. fifo_wr_en=req_valid[g] & ~fifo_full. fifo_din=req_data slice g (combinational mux, zero latency). fifo_prog_full is ignored while LOCKED.
- Accepted beat (fifo_wr_en=1) increments beat_cnt.
- Release: on an accepted beat with req_last[g]=1, OR when that accepted beat makes beat_cnt reach MAX_PKT_BEATS. On release: state becomes IDLE, grant_valid=0, rr_last=g, beat_cnt=0. A forced release (count reached without last) also sets err_overlen. If last and the count limit coincide on the same beat, this is a normal release with no error.
- There is always one idle cycle between packets. The same requester may be re-granted only if no other requester is valid.
- req_valid[g] dropping while LOCKED keeps the grant held (bubble), with no timeout.
- fifo_full=1 stalls with ready low and the grant held. The arbiter never asserts wr_en while full, so there is no overflow.
- err_clr and a set event in the same cycle: set wins.
- The beat_cnt width is $clog2(MAX_PKT_BEATS+1) and the counter never wraps.

Test Plan:
- Single packet: reset, req 2 sends 3 beats (0xA,0xB,0xC, last on C) -> grant_id=2 one cycle after valid; fifo_wr_en high 3 cycles with din A,B,C; grant_valid drops after C.
- Round-robin: reqs 0,1,3 each hold a 2-beat packet continuously -> grant order 0,1,3,0, one idle cycle between packets, no interleaved beats.
- Backpressure: fifo_full held high for 4 cycles mid-packet -> req_ready=0 and wr_en=0 for exactly those cycles, grant held, beats resume in order with none lost or duplicated.
- prog_full gating: prog_full=1 while IDLE with req 1 valid -> no grant; prog_full drops -> grant next cycle. prog_full rising mid-packet does not stall the packet.
- Overlength: MAX_PKT_BEATS=4, req 0 streams without last -> release after beat 4 and err_overlen=1; err_clr -> 0; beat 4 carrying last -> no error.
- Async reset mid-packet: assert reset between edges -> req_ready, wr_en and grant_valid go 0 immediately; after release, requester 0 wins a tie against requester 3.
